fetch_redirect_ctrl: RTL and testbench

Front-end sequencer that drives the program counter register's flush and stall controls. It arbitrates ROB redirect events (branch mispredict, exception, ertn, idle) into registered one-cycle flush pulses and runs the idle-wait state machine. It also tracks fetch-queue credits so a fetch block is only issued when it has a slot. It sits between the ROB/CSR, the I-cache request port and the fetch queue.

---
 rtl/fetch_redirect_ctrl_pkg.sv | 10 +
 rtl/fetch_redirect_ctrl_fq_credit_counter.sv | 29 ++
 rtl/fetch_redirect_ctrl.sv | 81 ++++++++
 tb/tb_fetch_redirect_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// fetch_redirect_ctrl_pkg: shared state/cause encodings and defaults for the fetch redirect controller
package fetch_redirect_ctrl_pkg;
  localparam int FQ_DEPTH_DEF = 8;
  localparam int FLUSH_BUBBLE_DEF = 2;
  typedef enum logic [1:0] {RUN, BUBBLE, IDLE_WAIT} state_t;
  typedef enum logic [1:0] {BR, EXCP, ERTN, IDLE} cause_t;
  function automatic logic [3:0] cause_onehot(input cause_t c);
    return 4'b0001 << c;
  endfunction
endpackage

// File: rtl/fetch_redirect_ctrl_fq_credit_counter.sv
// fq_credit_counter: fetch-queue credit tracking with flush reload and sticky overflow error
module fq_credit_counter #(
  parameter int FQ_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            fire,
  input  logic                            pop,
  output logic [$clog2(FQ_DEPTH+1)-1:0]   credits,
  output logic                            credit_err
);
  localparam int CW = $clog2(FQ_DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);
  logic overflow;
  logic [CW-1:0] credits_n;
  always_comb begin
    overflow = !flush && pop && !fire && (credits == FULL);
    credits_n = flush ? FULL : overflow ? credits : credits + CW'(pop) - CW'(fire);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      credits <= FULL;
      credit_err <= 1'b0;
    end else begin
      credits <= credits_n;
      credit_err <= credit_err | overflow;
    end
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: arbitrates ROB redirects into flush pulses, runs the bubble/idle FSM and gates fetch on credits
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int FQ_DEPTH = FQ_DEPTH_DEF,
  parameter int FLUSH_BUBBLE = FLUSH_BUBBLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic mispredict_rob,
  input  logic excp_rob,
  input  logic ertn_rob,
  input  logic idle_rob,
  input  logic irq_pending,
  input  logic icache_ready,
  input  logic fq_pop,
  output logic flush_pc_branch,
  output logic flush_pc_excp,
  output logic flush_pc_ertn,
  output logic flush_pc_idle,
  output logic flush_frontend,
  output logic stall_pc,
  output logic fetch_valid,
  output logic idle_o,
  output logic credit_err
);
  localparam logic [2:0] FB = 3'(FLUSH_BUBBLE);
  state_t state, state_n;
  cause_t win_cause, flush_cause;
  logic [2:0] cnt, cnt_n;
  logic ev, flush_vld, fetch_fire;
  logic [$clog2(FQ_DEPTH+1)-1:0] credits;
  fq_credit_counter #(.FQ_DEPTH(FQ_DEPTH)) u_credit (
    .clk(clk),
    .rst(rst),
    .flush(flush_vld),
    .fire(fetch_fire),
    .pop(fq_pop),
    .credits(credits),
    .credit_err(credit_err)
  );
  // While idling only a real redirect (exception/mispredict) may take the flush path
  always_comb begin
    win_cause = mispredict_rob ? BR : excp_rob ? EXCP : ertn_rob ? ERTN : IDLE;
    ev = (state == IDLE_WAIT) ? (mispredict_rob | excp_rob)
                              : (mispredict_rob | excp_rob | ertn_rob | idle_rob);
    state_n = state;
    cnt_n = cnt;
    if (ev) begin
      state_n = (win_cause == IDLE) ? IDLE_WAIT : BUBBLE;
      cnt_n = FB;
    end else if (state == BUBBLE) begin
      state_n = (cnt == 3'd0) ? RUN : BUBBLE;
      cnt_n = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
    end else if (state == IDLE_WAIT && irq_pending) begin
      state_n = BUBBLE;
      cnt_n = FB;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      cnt <= 3'd0;
      flush_vld <= 1'b0;
      flush_cause <= BR;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      flush_vld <= ev;
      flush_cause <= win_cause;
    end
  always_comb begin
    {flush_pc_idle, flush_pc_ertn, flush_pc_excp, flush_pc_branch} =
      flush_vld ? cause_onehot(flush_cause) : 4'b0000;
    flush_frontend = flush_vld;
    fetch_valid = (state == RUN) && (credits != '0);
    fetch_fire = fetch_valid && icache_ready;
    stall_pc = !fetch_fire;
    idle_o = (state == IDLE_WAIT);
  end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: table-driven scoreboard bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic mispredict_rob, excp_rob, ertn_rob, idle_rob, irq_pending, icache_ready, fq_pop;
  logic flush_pc_branch, flush_pc_excp, flush_pc_ertn, flush_pc_idle, flush_frontend;
  logic stall_pc, fetch_valid, idle_o, credit_err;
  logic [8:0] outs;
  int n_vec = 0, n_miss = 0;
  typedef struct packed {logic [6:0] in; logic [8:0] exp;} vec_t;
  vec_t tbl[$];
  logic [8:0] sbq[$];
  localparam logic [6:0] I_MIS = 7'b1000000, I_EXC = 7'b0100000, I_ERT = 7'b0010000,
    I_IDL = 7'b0001000, I_IRQ = 7'b0000100, I_ICR = 7'b0000010, I_POP = 7'b0000001;
  localparam logic [8:0] O_FV = 9'b100000000, O_ST = 9'b010000000, O_ID = 9'b001000000,
    O_CE = 9'b000100000, O_BR = 9'b000010000, O_EX = 9'b000001000, O_ER = 9'b000000100,
    O_IL = 9'b000000010, O_FF = 9'b000000001;

  fetch_redirect_ctrl dut (
    .clk(clk), .rst(rst),
    .mispredict_rob(mispredict_rob), .excp_rob(excp_rob), .ertn_rob(ertn_rob),
    .idle_rob(idle_rob), .irq_pending(irq_pending), .icache_ready(icache_ready),
    .fq_pop(fq_pop),
    .flush_pc_branch(flush_pc_branch), .flush_pc_excp(flush_pc_excp),
    .flush_pc_ertn(flush_pc_ertn), .flush_pc_idle(flush_pc_idle),
    .flush_frontend(flush_frontend), .stall_pc(stall_pc), .fetch_valid(fetch_valid),
    .idle_o(idle_o), .credit_err(credit_err)
  );

  always #5 clk = ~clk;
  assign outs = {fetch_valid, stall_pc, idle_o, credit_err, flush_pc_branch,
                 flush_pc_excp, flush_pc_ertn, flush_pc_idle, flush_frontend};

  task automatic add(input logic [6:0] i, input logic [8:0] o, input int n = 1);
    for (int r = 0; r < n; r++) tbl.push_back('{in: i, exp: o});
  endtask

  task automatic drive(input logic [6:0] i);
    {mispredict_rob, excp_rob, ertn_rob, idle_rob, irq_pending, icache_ready, fq_pop} = i;
  endtask

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got fv,st,id,ce,br,ex,er,il,ff=%b required %b", name, got, exp);
    end
  endtask

  initial begin
    drive(7'b0);
    add(I_ICR, O_FV, 8);
    add(I_ICR, O_ST);
    add(I_ICR | I_POP, O_ST);
    add(I_ICR, O_FV);
    add(I_ICR, O_ST);
    add(I_POP, O_ST);
    add(I_ICR | I_POP, O_FV);
    add(I_ICR, O_FV);
    add(I_ICR, O_ST);
    add(I_MIS | I_EXC | I_ICR, O_ST);
    add(I_ICR, O_ST | O_BR | O_FF);
    add(I_ICR, O_ST, 2);
    add(I_ICR, O_FV);
    add(I_ERT | I_ICR, O_FV);
    add(I_EXC, O_ST | O_ER | O_FF);
    add(7'b0, O_ST | O_EX | O_FF);
    add(7'b0, O_ST, 2);
    add(7'b0, O_FV | O_ST);
    add(I_POP, O_FV | O_ST);
    add(7'b0, O_FV | O_ST | O_CE);
    add(I_ICR, O_FV | O_CE, 8);
    add(I_ICR, O_ST | O_CE);
    add(I_IDL | I_ICR, O_ST | O_CE);
    add(I_ICR, O_ST | O_ID | O_IL | O_FF | O_CE);
    add(I_ICR, O_ST | O_ID | O_CE, 20);
    add(I_IRQ | I_ICR, O_ST | O_ID | O_CE);
    add(I_EXC | I_ICR, O_ST | O_CE);
    add(I_ICR, O_ST | O_EX | O_FF | O_CE);
    add(I_ICR, O_ST | O_CE, 2);
    add(7'b0, O_FV | O_ST | O_CE);
    add(I_IDL, O_FV | O_ST | O_CE);
    add(I_MIS, O_ST | O_ID | O_IL | O_FF | O_CE);
    add(7'b0, O_ST | O_BR | O_FF | O_CE);
    repeat (2) @(negedge clk);
    #2 chk("reset_state", outs, O_FV | O_ST);
    @(negedge clk);
    rst = 1'b1;
    foreach (tbl[k]) begin
      drive(tbl[k].in);
      sbq.push_back(tbl[k].exp);
      #2 chk($sformatf("vec%0d", k), outs, sbq.pop_front());
      @(negedge clk);
    end
    // async reset in the middle of a bubble
    drive(I_ICR);
    #2 chk("bubble_pre", outs, O_ST | O_CE);
    rst = 1'b0;
    #1 chk("bubble_rst", outs, O_FV);
    @(negedge clk);
    rst = 1'b1;
    drive(I_MIS | I_ICR);
    @(negedge clk);
    drive(I_ICR);
    #2 chk("pulse_pre", outs, O_ST | O_BR | O_FF);
    rst = 1'b0;
    #1 chk("pulse_rst", outs, O_FV);
    @(negedge clk);
    rst = 1'b1;
    drive(I_IDL);
    @(negedge clk);
    drive(7'b0);
    #2 chk("idle_pulse", outs, O_ST | O_ID | O_IL | O_FF);
    @(negedge clk);
    #2 chk("idle_pre", outs, O_ST | O_ID);
    rst = 1'b0;
    #1 chk("idle_rst", outs, O_FV | O_ST);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
